// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshakes and N/Z/C/V status.
// Stage 1 registers the accepted operation; stage 2 computes and registers the result.
// Optional build macro ALU_SAT_EN: ADD/SUB clamp to signed max/min on signed overflow.
module alu_pipe #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned SHW   = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             InValid,
    output logic             InReady,
    input  logic [5:0]       OPCode,
    input  logic [WIDTH-1:0] DataA,
    input  logic [WIDTH-1:0] DataB,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] ResultC,
    output logic [3:0]       Status,
    output logic             Illegal
);

    localparam logic [5:0] OP_ADD = 6'b000000;
    localparam logic [5:0] OP_SUB = 6'b000001;
    localparam logic [5:0] OP_AND = 6'b010000;
    localparam logic [5:0] OP_OR  = 6'b010001;
    localparam logic [5:0] OP_NOR = 6'b010010;
    localparam logic [5:0] OP_XOR = 6'b010011;
    localparam logic [5:0] OP_RLS = 6'b001100;
    localparam logic [5:0] OP_LLS = 6'b001101;
    localparam logic [5:0] OP_ARS = 6'b001110;

    localparam int unsigned MSB = WIDTH - 1;

    logic             s1_valid;
    logic [5:0]       s1_op;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    logic             out2_en;
    logic             s1_en;

    logic [WIDTH:0]   sum;
    logic [SHW-1:0]   amt;
    logic [WIDTH-1:0] res_c;
    logic             cy;
    logic             ov;
    logic             ill_c;
    logic [3:0]       st_c;

    // Pipeline advance terms; input readiness never looks at InValid
    always_comb begin
        out2_en = !OutValid || OutReady;
        s1_en   = !s1_valid || out2_en;
    end

    assign InReady = s1_en;

    // Stage 2 combinational datapath: result and flags from the stage-1 operation
    always_comb begin
        sum   = '0;
        res_c = '0;
        cy    = 1'b0;
        ov    = 1'b0;
        ill_c = 1'b0;
        amt   = s1_b[SHW-1:0];
        case (s1_op)
            OP_ADD: begin
                sum   = {1'b0, s1_a} + {1'b0, s1_b};
                res_c = sum[WIDTH-1:0];
                cy    = sum[WIDTH];
                ov    = (s1_a[MSB] == s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
            end
            OP_SUB: begin
                // A + ~B + 1: carry-out is set exactly when there is no borrow
                sum   = {1'b0, s1_a} + {1'b0, ~s1_b} + (WIDTH+1)'(1);
                res_c = sum[WIDTH-1:0];
                cy    = sum[WIDTH];
                ov    = (s1_a[MSB] != s1_b[MSB]) && (sum[MSB] != s1_a[MSB]);
            end
            OP_AND: res_c = s1_a & s1_b;
            OP_OR:  res_c = s1_a | s1_b;
            OP_NOR: res_c = ~(s1_a | s1_b);
            OP_XOR: res_c = s1_a ^ s1_b;
            OP_RLS: begin
                res_c = s1_a >> amt;
                cy    = (amt != '0) && s1_a[amt - SHW'(1)];
            end
            OP_LLS: begin
                res_c = s1_a << amt;
                cy    = (amt != '0) && s1_a[SHW'(WIDTH - 32'(amt))];
            end
            OP_ARS: begin
                res_c = WIDTH'($signed(s1_a) >>> amt);
                cy    = (amt != '0) && s1_a[amt - SHW'(1)];
            end
            default: ill_c = 1'b1;
        endcase
`ifdef ALU_SAT_EN
        // On overflow the true result has the sign of A, for both ADD and SUB
        if (ov) begin
            res_c = s1_a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        st_c = ill_c ? 4'b0000 : {cy, ov, (res_c == '0), res_c[MSB]};
    end

    // Stage 1 register: captures the operation on accept, holds while stalled
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            s1_valid <= 1'b0;
            s1_op    <= '0;
            s1_a     <= '0;
            s1_b     <= '0;
        end else if (s1_en) begin
            s1_valid <= InValid;
            if (InValid) begin
                s1_op <= OPCode;
                s1_a  <= DataA;
                s1_b  <= DataB;
            end
        end
    end

    // Output register: loads the computed result when the consumer can take it
    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            OutValid <= 1'b0;
            ResultC  <= '0;
            Status   <= '0;
            Illegal  <= 1'b0;
        end else if (out2_en) begin
            OutValid <= s1_valid;
            if (s1_valid) begin
                ResultC <= res_c;
                Status  <= st_c;
                Illegal <= ill_c;
            end
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe (WIDTH=32); builds with or without ALU_SAT_EN.
module tb_alu_pipe;

    typedef struct packed {
        logic [31:0] r;
        logic [3:0]  st;
        logic        ill;
    } res_t;

    localparam logic [5:0] ADD = 6'b000000;
    localparam logic [5:0] SUB = 6'b000001;
    localparam logic [5:0] AND = 6'b010000;
    localparam logic [5:0] OR  = 6'b010001;
    localparam logic [5:0] NOR = 6'b010010;
    localparam logic [5:0] XOR = 6'b010011;
    localparam logic [5:0] RLS = 6'b001100;
    localparam logic [5:0] LLS = 6'b001101;
    localparam logic [5:0] ARS = 6'b001110;

    localparam longint SMAX = 64'sd2147483647;
    localparam longint SMIN = -64'sd2147483648;

    logic        Clock    = 1'b0;
    logic        ResetN   = 1'b0;
    logic        InValid  = 1'b0;
    logic        InReady;
    logic [5:0]  OPCode   = '0;
    logic [31:0] DataA    = '0;
    logic [31:0] DataB    = '0;
    logic        OutValid;
    logic        OutReady = 1'b0;
    logic [31:0] ResultC;
    logic [3:0]  Status;
    logic        Illegal;

    int total = 0;
    int bad   = 0;

    res_t exp_q[$];
    res_t obs_q[$];

    alu_pipe #(.WIDTH(32)) dut (
        .Clock    (Clock),
        .ResetN   (ResetN),
        .InValid  (InValid),
        .InReady  (InReady),
        .OPCode   (OPCode),
        .DataA    (DataA),
        .DataB    (DataB),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .ResultC  (ResultC),
        .Status   (Status),
        .Illegal  (Illegal)
    );

    always #5 Clock = ~Clock;

    // Record every output handshake; inputs only change just after a rising edge
    always @(negedge Clock) begin
        if (ResetN && OutValid && OutReady)
            obs_q.push_back({ResultC, Status, Illegal});
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "watchdog expired");
    end

    // Reference model, written from the op table rather than from the RTL structure
    function automatic res_t model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b);
        longint unsigned ut;
        longint          st;
        logic [63:0]     t;
        logic [31:0]     r;
        logic            c;
        logic            v;
        int              amt;
        r = '0; c = 1'b0; v = 1'b0; st = 0;
        amt = int'(b[4:0]);
        case (op)
            ADD: begin
                ut = 64'(a) + 64'(b);
                r  = ut[31:0];
                c  = ut[32];
                st = longint'($signed(a)) + longint'($signed(b));
                v  = (st > SMAX) || (st < SMIN);
            end
            SUB: begin
                r  = a - b;
                c  = (a >= b);
                st = longint'($signed(a)) - longint'($signed(b));
                v  = (st > SMAX) || (st < SMIN);
            end
            AND: r = a & b;
            OR:  r = a | b;
            NOR: r = ~(a | b);
            XOR: r = a ^ b;
            RLS: begin r = a >> amt; t = {a, 32'h0} >> amt; c = t[31]; end
            LLS: begin r = a << amt; t = {32'h0, a} << amt; c = t[32]; end
            ARS: begin r = 32'($signed(a) >>> amt); t = {a, 32'h0} >> amt; c = t[31]; end
            default: return {32'h0, 4'h0, 1'b1};
        endcase
`ifdef ALU_SAT_EN
        if (v) r = (st < 0) ? 32'h80000000 : 32'h7FFFFFFF;
`endif
        return {r, {c, v, (r == 32'h0), r[31]}, 1'b0};
    endfunction

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // Offer one op and hold it until accepted; expected result enters the scoreboard on accept
    task automatic send(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b, input res_t e);
        OPCode = op; DataA = a; DataB = b; InValid = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge Clock);
            if (InReady) begin
                exp_q.push_back(e);
                tick();
                InValid = 1'b0;
                return;
            end
            tick();
        end
        total++; bad++;
        $display("FAIL send_timeout: op=%b got no accept, want accept within 64 cycles", op);
        InValid = 1'b0;
    endtask

    // Wait until the DUT has produced as many results as the scoreboard expects
    task automatic wait_out(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (obs_q.size() >= exp_q.size()) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        #2;
        total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL rst_outvalid: got %b want 0", OutValid); end
        total++; if (ResultC !== 32'h0) begin bad++; $display("FAIL rst_result: got %h want 00000000", ResultC); end
        total++; if (Status !== 4'h0) begin bad++; $display("FAIL rst_status: got %b want 0000", Status); end
        total++; if (Illegal !== 1'b0) begin bad++; $display("FAIL rst_illegal: got %b want 0", Illegal); end
        repeat (2) @(posedge Clock);
        #1 ResetN = 1'b1;
        tick();
        total++; if (InReady !== 1'b1) begin bad++; $display("FAIL rst_inready: got %b want 1", InReady); end
    endtask

    task automatic test_arith();
        bit ok;
        res_t e, g, e_ovf;
`ifdef ALU_SAT_EN
        e_ovf = {32'h7FFFFFFF, 4'b0100, 1'b0};
`else
        e_ovf = {32'h80000000, 4'b0101, 1'b0};
`endif
        OutReady = 1'b1;
        send(ADD, 32'h7FFFFFFF, 32'h1, e_ovf);
        total++; if (OutValid !== 1'b0) begin bad++; $display("FAIL add_lat_early: got OutValid=%b want 0 one cycle after accept", OutValid); end
        tick();
        total++; if (OutValid !== 1'b1) begin bad++; $display("FAIL add_lat_two: got OutValid=%b want 1 two cycles after accept", OutValid); end
        send(ADD, 32'hFFFFFFFF, 32'h1, {32'h0, 4'b1010, 1'b0});
        send(SUB, 32'h5, 32'h5, {32'h0, 4'b1010, 1'b0});
        send(SUB, 32'h3, 32'h5, {32'hFFFFFFFE, 4'b0001, 1'b0});
        wait_out(ok);
        total++; if (!ok) begin bad++; $display("FAIL arith_drain: got %0d results want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL arith_result: got r=%h st=%b ill=%b want r=%h st=%b ill=%b", g.r, g.st, g.ill, e.r, e.st, e.ill); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_shift_logic();
        bit ok;
        res_t e, g;
        OutReady = 1'b1;
        send(RLS, 32'h80000001, 32'h1,  {32'h40000000, 4'b1000, 1'b0});
        send(ARS, 32'h80000000, 32'd31, {32'hFFFFFFFF, 4'b0001, 1'b0});
        send(LLS, 32'h12345678, 32'h20, {32'h12345678, 4'b0000, 1'b0});
        send(LLS, 32'h80000001, 32'h1,  {32'h00000002, 4'b1000, 1'b0});
        send(AND, 32'hF0F0F0F0, 32'hFF00FF00, {32'hF000F000, 4'b0001, 1'b0});
        send(OR,  32'hF0F0F0F0, 32'hFF00FF00, {32'hFFF0FFF0, 4'b0001, 1'b0});
        send(NOR, 32'hF0F0F0F0, 32'hFF00FF00, {32'h000F000F, 4'b0000, 1'b0});
        send(XOR, 32'hF0F0F0F0, 32'hFF00FF00, {32'h0FF00FF0, 4'b0000, 1'b0});
        send(AND, 32'h0000000F, 32'h000000F0, {32'h00000000, 4'b0010, 1'b0});
        wait_out(ok);
        total++; if (!ok) begin bad++; $display("FAIL shlog_drain: got %0d results want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL shlog_result: got r=%h st=%b ill=%b want r=%h st=%b ill=%b", g.r, g.st, g.ill, e.r, e.st, e.ill); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_illegal();
        bit ok;
        res_t e, g;
        OutReady = 1'b1;
        send(6'b111111, 32'hDEADBEEF, 32'h12345678, {32'h0, 4'b0000, 1'b1});
        tick();
        total++; if (OutValid !== 1'b1 || Illegal !== 1'b1) begin bad++; $display("FAIL ill_lat: got OutValid=%b Illegal=%b want 1 1", OutValid, Illegal); end
        send(ADD, 32'h1, 32'h2, {32'h3, 4'b0000, 1'b0});
        wait_out(ok);
        total++; if (!ok) begin bad++; $display("FAIL ill_drain: got %0d results want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL ill_result: got r=%h st=%b ill=%b want r=%h st=%b ill=%b", g.r, g.st, g.ill, e.r, e.st, e.ill); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back();
        bit ok;
        res_t e, g;
        int acc;
        acc = 0;
        OutReady = 1'b0;
        for (int cyc = 0; cyc < 40 && acc < 4; cyc++) begin
            OPCode = ADD;
            DataA = 32'(acc + 1) << 28;
            DataB = 32'(acc + 1);
            InValid = 1'b1;
            OutReady = (cyc >= 5);
            @(negedge Clock);
            if (cyc == 2) begin
                total++; if (InReady !== 1'b0) begin bad++; $display("FAIL b2b_inready: got %b want 0 after two accepts", InReady); end
                total++; if (acc !== 2) begin bad++; $display("FAIL b2b_accepts: got %0d want 2 before stall", acc); end
            end
            if (cyc >= 2 && cyc <= 4) begin
                total++;
                if (OutValid !== 1'b1 || ResultC !== 32'h10000001) begin
                    bad++; $display("FAIL b2b_hold: cycle %0d got valid=%b r=%h want valid=1 r=10000001", cyc, OutValid, ResultC);
                end
            end
            if (InValid && InReady) begin
                exp_q.push_back(model(OPCode, DataA, DataB));
                acc++;
            end
            tick();
        end
        InValid = 1'b0;
        OutReady = 1'b1;
        wait_out(ok);
        total++; if (!ok || exp_q.size() != 4) begin bad++; $display("FAIL b2b_drain: got %0d results of %0d expected, want 4", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL b2b_order: got r=%h st=%b want r=%h st=%b", g.r, g.st, e.r, e.st); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_random();
        bit ok;
        res_t e, g;
        int sent;
        logic [31:0] spec [4];
        spec[0] = 32'h0; spec[1] = 32'h7FFFFFFF; spec[2] = 32'h80000000; spec[3] = 32'hFFFFFFFF;
        sent = 0;
        InValid = 1'b0;
        for (int cyc = 0; cyc < 3000 && sent < 80; cyc++) begin
            if (!InValid) begin
                if ($urandom_range(0, 3) != 0) begin
                    case ($urandom_range(0, 9))
                        0: OPCode = ADD;  1: OPCode = SUB;  2: OPCode = AND;
                        3: OPCode = OR;   4: OPCode = NOR;  5: OPCode = XOR;
                        6: OPCode = RLS;  7: OPCode = LLS;  8: OPCode = ARS;
                        default: OPCode = 6'b100111;
                    endcase
                    DataA = ($urandom_range(0, 2) == 0) ? spec[$urandom_range(0, 3)] : $urandom;
                    DataB = ($urandom_range(0, 2) == 0) ? spec[$urandom_range(0, 3)] : $urandom;
                    InValid = 1'b1;
                end
            end
            OutReady = ($urandom_range(0, 3) != 0);
            @(negedge Clock);
            if (InValid && InReady) begin
                exp_q.push_back(model(OPCode, DataA, DataB));
                sent++;
                @(posedge Clock); #1;
                InValid = 1'b0;
            end else begin
                tick();
            end
        end
        InValid = 1'b0;
        OutReady = 1'b1;
        wait_out(ok);
        total++; if (!ok) begin bad++; $display("FAIL rand_drain: got %0d results want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL rand_result: got r=%h st=%b ill=%b want r=%h st=%b ill=%b", g.r, g.st, g.ill, e.r, e.st, e.ill); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_inflight();
        bit ok;
        res_t e, g;
        OutReady = 1'b0;
        send(ADD, 32'h11, 32'h22, model(ADD, 32'h11, 32'h22));
        send(SUB, 32'h99, 32'h11, model(SUB, 32'h99, 32'h11));
        #2 ResetN = 1'b0;
        #1;
        total++;
        if (OutValid !== 1'b0 || ResultC !== 32'h0 || Status !== 4'h0 || Illegal !== 1'b0) begin
            bad++; $display("FAIL rst_async: got valid=%b r=%h st=%b ill=%b want all zero", OutValid, ResultC, Status, Illegal);
        end
        exp_q.delete(); obs_q.delete();
        OutReady = 1'b1;
        repeat (2) @(posedge Clock);
        #1 ResetN = 1'b1;
        tick();
        total++; if (InReady !== 1'b1) begin bad++; $display("FAIL rst_rel_inready: got %b want 1", InReady); end
        repeat (5) tick();
        total++; if (obs_q.size() != 0 || OutValid !== 1'b0) begin bad++; $display("FAIL rst_stale: got %0d results valid=%b want 0 0", obs_q.size(), OutValid); end
        send(ADD, 32'd10, 32'd20, {32'd30, 4'b0000, 1'b0});
        wait_out(ok);
        total++; if (!ok) begin bad++; $display("FAIL rst_post_drain: got %0d results want %0d", obs_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); g = obs_q.pop_front();
            total++;
            if (g !== e) begin bad++; $display("FAIL rst_post_result: got r=%h st=%b ill=%b want r=%h st=%b ill=%b", g.r, g.st, g.ill, e.r, e.st, e.ill); end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    initial begin
        test_reset();
        test_arith();
        test_shift_logic();
        test_illegal();
        test_back_to_back();
        test_random();
        test_reset_inflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
